bias_scale_act_mc: RTL and testbench

//  Multi-lane successor to the single-lane bias/scale/activation stage. Takes N_LANES MAC results per beat
//  (same output channel), adds a per-channel bias, multiplies by a per-channel scale, rounds-and-shifts, applies a

---
 rtl/bias_scale_act_mc.sv | 201 ++++++++++++++++++++
 tb/tb_bias_scale_act_mc.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bias_scale_act_mc.sv
// Multi-lane bias / scale / round-shift / activation / saturate stage with a per-channel parameter table.
// Four-stage pipeline (capture+table read, bias add, multiply, descale+act+sat) under a single global stall.

module bsa_lane #(
  parameter int MB = 24,
  parameter int PB = 16,
  parameter int AB = 8,
  parameter int SW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  input  logic [MB-1:0] din,
  input  logic [PB-1:0] bias,
  input  logic [PB-1:0] scale,
  input  logic [1:0]    mode,
  input  logic [SW-1:0] shift,
  output logic [AB-1:0] dout
);
  localparam int SUM_W  = MB + 1;
  localparam int PROD_W = MB + PB + 1;
  localparam int RND_W  = PROD_W + 1;
  localparam int ACC_W  = RND_W + 2;
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << (AB - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MINV = -MAXV;

  logic [MB-1:0]            d0_q, d0_d;
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic [AB-1:0]            dout_q, dout_d;
  logic signed [RND_W-1:0]  rnd, rsum, sh;
  logic signed [ACC_W-1:0]  sh_e, x3, act;
  logic                     big;

  always_comb begin
    d0_d   = d0_q;
    sum_d  = sum_q;
    prod_d = prod_q;
    dout_d = dout_q;
    // Once the shift reaches the product width the rounded result is always 0.
    big  = int'(shift) >= PROD_W;
    rnd  = RND_W'(1) << (shift - SW'(1));
    rsum = $signed({prod_q[PROD_W-1], prod_q}) + rnd;
    if (shift == '0)
      sh = $signed({prod_q[PROD_W-1], prod_q});
    else if (big)
      sh = '0;
    else
      sh = rsum >>> shift;
    sh_e = $signed({{2{sh[RND_W-1]}}, sh});
    x3   = sh_e + (sh_e <<< 1);
    case (mode)
      2'd1:    act = sh_e[ACC_W-1] ? '0 : sh_e;
      2'd2:    act = sh_e[ACC_W-1] ? (x3 >>> 5) : sh_e;
      default: act = sh_e;
    endcase
    if (adv) begin
      d0_d   = din;
      sum_d  = $signed({d0_q[MB-1], d0_q}) + $signed({{(SUM_W - PB){bias[PB-1]}}, bias});
      prod_d = $signed({{PB{sum_q[SUM_W-1]}}, sum_q}) * $signed({{(PROD_W - PB){scale[PB-1]}}, scale});
      if (act > MAXV)      dout_d = MAXV[AB-1:0];
      else if (act < MINV) dout_d = MINV[AB-1:0];
      else                 dout_d = act[AB-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d0_q   <= '0;
      sum_q  <= '0;
      prod_q <= '0;
      dout_q <= '0;
    end else begin
      d0_q   <= d0_d;
      sum_q  <= sum_d;
      prod_q <= prod_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;
endmodule

module bias_scale_act_mc #(
  parameter int N_LANES      = 4,
  parameter int MAC_OUT_BITS = 24,
  parameter int PARAM_BITS   = 16,
  parameter int ACT_BITS     = 8,
  parameter int CH_DEPTH     = 64,
  parameter int SHIFT_W      = 6,
  parameter int CH_W         = $clog2(CH_DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_we,
  input  logic [CH_W-1:0]                   cfg_addr,
  input  logic [PARAM_BITS-1:0]             cfg_bias,
  input  logic [PARAM_BITS-1:0]             cfg_scale,
  input  logic [CH_W-1:0]                   cfg_last_ch,
  input  logic [1:0]                        act_mode,
  input  logic [SHIFT_W-1:0]                scale_shift,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_first,
  input  logic [N_LANES*MAC_OUT_BITS-1:0]   in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [CH_W-1:0]                   out_ch,
  output logic [N_LANES*ACT_BITS-1:0]       out_data
);
  localparam int STAGES = 4;

  typedef struct packed {
    logic [1:0]         mode;
    logic [SHIFT_W-1:0] shift;
    logic [CH_W-1:0]    ch;
  } ctl_t;

  logic [PARAM_BITS-1:0] bias_mem  [CH_DEPTH];
  logic [PARAM_BITS-1:0] scale_mem [CH_DEPTH];

  logic                  adv, accept;
  logic [CH_W-1:0]       beat_ch;
  logic [CH_W-1:0]       cnt_q, cnt_d;
  logic [STAGES-1:0]     vld_pipe_q, vld_pipe_d;
  ctl_t [STAGES-1:0]     ctl_q, ctl_d;
  ctl_t                  ctl_in;
  logic [PARAM_BITS-1:0] bias0_q, bias0_d, scale0_q, scale0_d, scale1_q, scale1_d;

  always_comb begin
    adv     = ~vld_pipe_q[STAGES-1] | out_ready;
    accept  = in_valid & adv;
    beat_ch = in_first ? '0 : cnt_q;
    ctl_in  = '{mode: act_mode, shift: scale_shift, ch: beat_ch};

    cnt_d = cnt_q;
    if (accept)
      cnt_d = (beat_ch == cfg_last_ch) ? '0 : beat_ch + CH_W'(1);

    vld_pipe_d = vld_pipe_q;
    ctl_d      = ctl_q;
    bias0_d    = bias0_q;
    scale0_d   = scale0_q;
    scale1_d   = scale1_q;
    // Bubbles shift along with beats, so a stall freezes the whole pipe in place.
    if (adv) begin
      vld_pipe_d = {vld_pipe_q[STAGES-2:0], in_valid};
      ctl_d[0]   = ctl_in;
      for (int s = 1; s < STAGES; s++) ctl_d[s] = ctl_q[s-1];
      bias0_d    = bias_mem[beat_ch];
      scale0_d   = scale_mem[beat_ch];
      scale1_d   = scale0_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      vld_pipe_q <= '0;
      ctl_q      <= '0;
      bias0_q    <= '0;
      scale0_q   <= '0;
      scale1_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      vld_pipe_q <= vld_pipe_d;
      ctl_q      <= ctl_d;
      bias0_q    <= bias0_d;
      scale0_q   <= scale0_d;
      scale1_q   <= scale1_d;
    end
  end

  // Table is not reset; a same-cycle read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      bias_mem[cfg_addr]  <= cfg_bias;
      scale_mem[cfg_addr] <= cfg_scale;
    end
  end

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    bsa_lane #(
      .MB(MAC_OUT_BITS), .PB(PARAM_BITS), .AB(ACT_BITS), .SW(SHIFT_W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .adv   (adv),
      .din   (in_data[g*MAC_OUT_BITS +: MAC_OUT_BITS]),
      .bias  (bias0_q),
      .scale (scale1_q),
      .mode  (ctl_q[2].mode),
      .shift (ctl_q[2].shift),
      .dout  (out_data[g*ACT_BITS +: ACT_BITS])
    );
  end

  assign in_ready  = adv;
  assign out_valid = vld_pipe_q[STAGES-1];
  assign out_ch    = ctl_q[STAGES-1].ch;
endmodule

// File: tb/tb_bias_scale_act_mc.sv
// Directed bench for bias_scale_act_mc: hand-computed lane results, channel sequencing, stall and reset behaviour.
module tb_bias_scale_act_mc;
  localparam int NL = 4, MB = 24, PB = 16, AB = 8, CD = 64, CW = 6, SW = 6;

  logic clk, rst, cfg_we, in_valid, in_ready, in_first, out_valid, out_ready;
  logic [CW-1:0] cfg_addr, cfg_last_ch, out_ch;
  logic [PB-1:0] cfg_bias, cfg_scale;
  logic [1:0] act_mode;
  logic [SW-1:0] scale_shift;
  logic [NL*MB-1:0] in_data;
  logic [NL*AB-1:0] out_data;

  bias_scale_act_mc #(
    .N_LANES(NL), .MAC_OUT_BITS(MB), .PARAM_BITS(PB), .ACT_BITS(AB), .CH_DEPTH(CD), .SHIFT_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_bias(cfg_bias),
    .cfg_scale(cfg_scale), .cfg_last_ch(cfg_last_ch), .act_mode(act_mode),
    .scale_shift(scale_shift), .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [37:0] got_q[$], exp_q[$];
  logic hold_chk = 1'b0, held = 1'b0;
  logic [37:0] held_v;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic logic [95:0] pin(input int a, input int b, input int c, input int d);
    return {d[23:0], c[23:0], b[23:0], a[23:0]};
  endfunction

  task automatic expect_beat(input int ch, input int a, input int b, input int c, input int d);
    exp_q.push_back({ch[5:0], pk(a, b, c, d)});
  endtask

  task automatic cfg(input int a, input int b, input int s);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = a[5:0]; cfg_bias = b[15:0]; cfg_scale = s[15:0];
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic first, input int a, input int b, input int c, input int d,
                      input int mode, input int sh);
    @(posedge clk); #1;
    in_valid = 1'b1; in_first = first; in_data = pin(a, b, c, d);
    act_mode = mode[1:0]; scale_shift = sh[5:0];
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (8) @(negedge clk);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // Output collector plus stall-hold and ready checks while streaming under backpressure.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got_q.push_back({out_ch, out_data});
    if (hold_chk) begin
      chk("in_ready_adv", in_ready, !out_valid || out_ready);
      if (held) chk("hold_stable", {out_valid, out_ch, out_data}, {1'b1, held_v});
      held   = out_valid && !out_ready;
      held_v = {out_ch, out_data};
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cyc;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_bias = '0; cfg_scale = '0; cfg_last_ch = 6'd3;
    act_mode = '0; scale_shift = '0; in_valid = 1'b0; in_first = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1 rst = 1'b0;

    // Basic ReLU beat with latency check
    cfg(0, 10, 256);
    send(1'b1, 100, -50, 0, 5, 1, 8);
    idle();
    expect_beat(0, 110, 0, 10, 15);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("t1_lat%0d", i), out_valid, 0);
    end
    @(negedge clk);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, pk(110, 0, 10, 15));
    chk("t1_ch", out_ch, 0);
    drain("t1");

    // Channel counter wrap and in_first restart; bias per channel = channel index
    cfg(0, 0, 1); cfg(1, 1, 1); cfg(2, 2, 1);
    cfg_last_ch = 6'd2;
    for (int i = 0; i < 7; i++) begin
      send(i == 0, i, -i, 2 * i, 0, 0, 0);
      expect_beat(i % 3, i + i % 3, -i + i % 3, 2 * i + i % 3, i % 3);
    end
    idle();
    drain("t2a");
    begin
      int chs[7] = '{0, 1, 2, 0, 0, 1, 2};
      for (int i = 0; i < 7; i++) begin
        send(i == 0 || i == 4, i + 10, -i, 2 * i, 0, 0, 0);
        expect_beat(chs[i], i + 10 + chs[i], -i + chs[i], 2 * i + chs[i], chs[i]);
      end
    end
    idle();
    drain("t2b");

    // Activation modes and symmetric saturation, mode changed per beat
    cfg(0, 0, 1);
    send(1'b1, -100, 300, -300, 0, 2, 0);         expect_beat(0, -10, 127, -29, 0);
    send(1'b1, -100, 300, -300, -128, 0, 0);      expect_beat(0, -100, 127, -127, -127);
    send(1'b1, -100, 300, -300, -128, 1, 0);      expect_beat(0, 0, 127, 0, 0);
    send(1'b1, 8388607, -8388608, 1, -1, 3, 0);   expect_beat(0, 127, -127, 1, -1);
    send(1'b1, -1, -32, -33, 31, 2, 0);           expect_beat(0, -1, -3, -4, 31);
    idle();
    drain("t3");

    // Round-half-up descale, negative scale, oversized shift
    cfg(0, 0, 3); cfg(1, -20, -2);
    send(1'b1, 1, -1, 2, -2, 0, 1);               expect_beat(0, 2, -1, 3, -3);
    send(1'b1, 100, -100, 5, 0, 0, 5);            expect_beat(0, 9, -9, 0, 0);
    send(1'b0, 30, -30, 0, 100, 0, 0);            expect_beat(1, -20, 100, 40, -127);
    send(1'b1, 1000, -1000, 0, 0, 0, 63);         expect_beat(0, 0, 0, 0, 0);
    idle();
    drain("t4");

    // Streaming under random backpressure
    cfg(0, 0, 1); cfg(1, 1, 1);
    for (int i = 0; i < 10; i++) expect_beat(i % 3, i + i % 3, -i + i % 3, 3 * i + i % 3, 50 + i % 3);
    hold_chk = 1'b1;
    k = 0; cyc = 0;
    while (k < 10 && cyc < 400) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid = 1'b1; in_first = (k == 0); in_data = pin(k, -k, 3 * k, 50);
      act_mode = 2'd0; scale_shift = '0;
      @(negedge clk);
      if (in_ready) k++;
      cyc++;
    end
    chk("t5_accepted", k, 10);
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0;
    repeat (6) begin
      @(posedge clk); #1 out_ready = ($urandom_range(0, 1) != 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    drain("t5");
    hold_chk = 1'b0;

    // Reset with beats in flight, then same-cycle table write/read
    cfg_last_ch = 6'd5;
    send(1'b1, 1, 1, 1, 1, 0, 0);
    send(1'b0, 2, 2, 2, 2, 0, 0);
    send(1'b0, 3, 3, 3, 3, 0, 0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_valid", out_valid, 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("t6_no_stale%0d", i), out_valid, 0);
    end
    chk("t6_no_stale_q", got_q.size(), 0);
    got_q.delete();
    @(posedge clk); #1;
    in_valid = 1'b1; in_first = 1'b0; in_data = pin(1, 2, 3, 4); act_mode = 2'd0; scale_shift = '0;
    cfg_we = 1'b1; cfg_addr = 6'd0; cfg_bias = 16'd50; cfg_scale = 16'd1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    @(posedge clk); #1;
    in_first = 1'b1;
    idle();
    expect_beat(0, 1, 2, 3, 4);
    expect_beat(1, 2, 3, 4, 5);
    expect_beat(0, 51, 52, 53, 54);
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
